// File: rtl/soc_optimsoc_config.sv
// rtl/soc_optimsoc_config.sv - shared configuration types, register offsets and FLAGS packing
package soc_optimsoc_config;

  localparam logic [15:0] NACONF_VERSION        = 16'h0000;
  localparam logic [15:0] NACONF_TILEID         = 16'h0004;
  localparam logic [15:0] NACONF_NUMTILES       = 16'h0008;
  localparam logic [15:0] NACONF_COREBASE       = 16'h000C;
  localparam logic [15:0] NACONF_LMEM_SIZE      = 16'h0010;
  localparam logic [15:0] NACONF_GMEM_SIZE      = 16'h0014;
  localparam logic [15:0] NACONF_GMEM_TILE      = 16'h0018;
  localparam logic [15:0] NACONF_FLAGS          = 16'h001C;
  localparam logic [15:0] NACONF_NA_DMA_ENTRIES = 16'h0020;
  localparam logic [15:0] NACONF_NUMCTS         = 16'h0024;
  localparam logic [15:0] NACONF_CORES_PER_TILE = 16'h0028;
  localparam logic [15:0] NACONF_TOTAL_CORES    = 16'h002C;
  localparam logic [15:0] NACONF_CYCLES         = 16'h0030;
  localparam logic [15:0] NACONF_SCRATCH        = 16'h0034;
  localparam logic [15:0] NACONF_CTLIST         = 16'h0200;

  localparam logic [31:0] NACONF_VERSION_VALUE  = 32'h0001_0000;

  typedef struct packed {
    logic [31:0]       numtiles;
    logic [31:0]       lmem_size;
    logic [31:0]       gmem_size;
    logic [31:0]       gmem_tile;
    logic [31:0]       na_dma_entries;
    logic [31:0]       numcts;
    logic [31:0]       cores_per_tile;
    logic [31:0]       total_num_cores;
    logic              na_enable_mpsimple;
    logic              na_enable_dma;
    logic              na_dma_genirq;
    logic              enable_dm;
    logic              enable_pgas;
    logic              use_debug;
    logic              noc_enable_vchannels;
    logic [63:0][15:0] ctlist;
  } config_t;

  localparam config_t CONFIG_DEFAULT = '0;

  // IDLE/RESPOND mirrors whether a response is currently on the bus
  typedef enum logic {
    NACONF_IDLE,
    NACONF_RESPOND
  } naconf_state_t;

  function automatic logic [31:0] naconf_flags(config_t c);
    return {25'b0, c.noc_enable_vchannels, c.use_debug, c.enable_pgas,
            c.enable_dm, c.na_dma_genirq, c.na_enable_dma, c.na_enable_mpsimple};
  endfunction

endpackage

// File: rtl/soc_networkadapter_configuration_if.sv
// rtl/soc_networkadapter_configuration_if.sv - Wishbone slave bus bundle
interface soc_networkadapter_configuration_if;
  logic [15:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/soc_networkadapter_configuration.sv
// rtl/soc_networkadapter_configuration.sv - tile configuration register slave with cycle counter and scratch
module soc_networkadapter_configuration
  import soc_optimsoc_config::*;
#(
  parameter config_t CONFIG   = CONFIG_DEFAULT,
  parameter int      TILEID   = 0,
  parameter int      COREBASE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  soc_networkadapter_configuration_if.slave   wb
);

  naconf_state_t state, state_next;
  logic [15:0]   offset;
  logic [5:0]    ct_idx;
  logic [31:0]   rd_data, dat_next, cycles, scratch;
  logic          accept, mapped, is_cycles, is_scratch, rw_ok, write_en;
  logic          ack_next, err_next;
  logic          unused_adr_lsb;

  assign offset         = {wb.wb_adr_i[15:2], 2'b00};
  assign ct_idx         = wb.wb_adr_i[7:2];
  assign unused_adr_lsb = &{1'b0, wb.wb_adr_i[1:0]};
  assign accept   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
  assign rw_ok    = (is_cycles | is_scratch) & (wb.wb_sel_i == 4'hF);
  assign write_en = accept & wb.wb_we_i & rw_ok;

  always_comb begin
    rd_data    = '0;
    mapped     = 1'b1;
    is_cycles  = 1'b0;
    is_scratch = 1'b0;
    if (offset[15:8] == NACONF_CTLIST[15:8]) begin
      // entries beyond NUMCTS read as zero but still acknowledge
      if ({26'b0, ct_idx} < CONFIG.numcts)
        rd_data = {16'h0, CONFIG.ctlist[ct_idx]};
    end else begin
      case (offset)
        NACONF_VERSION:        rd_data = NACONF_VERSION_VALUE;
        NACONF_TILEID:         rd_data = 32'(TILEID);
        NACONF_NUMTILES:       rd_data = CONFIG.numtiles;
        NACONF_COREBASE:       rd_data = 32'(COREBASE);
        NACONF_LMEM_SIZE:      rd_data = CONFIG.lmem_size;
        NACONF_GMEM_SIZE:      rd_data = CONFIG.gmem_size;
        NACONF_GMEM_TILE:      rd_data = CONFIG.gmem_tile;
        NACONF_FLAGS:          rd_data = naconf_flags(CONFIG);
        NACONF_NA_DMA_ENTRIES: rd_data = CONFIG.na_dma_entries;
        NACONF_NUMCTS:         rd_data = CONFIG.numcts;
        NACONF_CORES_PER_TILE: rd_data = CONFIG.cores_per_tile;
        NACONF_TOTAL_CORES:    rd_data = CONFIG.total_num_cores;
        NACONF_CYCLES: begin
          rd_data   = cycles;
          is_cycles = 1'b1;
        end
        NACONF_SCRATCH: begin
          rd_data    = scratch;
          is_scratch = 1'b1;
        end
        default:               mapped = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    dat_next   = '0;
    case (state)
      NACONF_IDLE: begin
        if (accept) begin
          state_next = NACONF_RESPOND;
          err_next   = ~mapped | (wb.wb_we_i & ~rw_ok);
          ack_next   = ~err_next;
          dat_next   = (wb.wb_we_i | err_next) ? '0 : rd_data;
        end
      end
      NACONF_RESPOND: state_next = NACONF_IDLE;
      default:        state_next = NACONF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NACONF_IDLE;
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      state       <= state_next;
      wb.wb_ack_o <= ack_next;
      wb.wb_err_o <= err_next;
      wb.wb_dat_o <= dat_next;
    end
  end

  // a CYCLES write replaces that cycle's increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      scratch <= '0;
    end else begin
      if (write_en && is_cycles) cycles <= wb.wb_dat_i;
      else                       cycles <= cycles + 32'd1;
      if (write_en && is_scratch) scratch <= wb.wb_dat_i;
    end
  end

endmodule

// File: tb/tb_soc_networkadapter_configuration.sv
// tb/tb_soc_networkadapter_configuration.sv - self-checking bench for the configuration register slave
module tb_soc_networkadapter_configuration;
  import soc_optimsoc_config::*;

  function automatic config_t make_cfg();
    config_t c;
    c = '0;
    c.numtiles        = 32'd4;
    c.lmem_size       = 32'h0000_8000;
    c.gmem_size       = 32'h0010_0000;
    c.gmem_tile       = 32'd0;
    c.na_dma_entries  = 32'd4;
    c.numcts          = 32'd2;
    c.cores_per_tile  = 32'd2;
    c.total_num_cores = 32'd8;
    c.na_enable_dma   = 1'b1;
    c.use_debug       = 1'b1;
    c.ctlist[0]       = 16'h0000;
    c.ctlist[1]       = 16'h0005;
    c.ctlist[2]       = 16'h0077;
    return c;
  endfunction

  localparam config_t TB_CFG = make_cfg();

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  soc_networkadapter_configuration_if wb ();

  soc_networkadapter_configuration #(
    .CONFIG   (TB_CFG),
    .TILEID   (3),
    .COREBASE (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        exp_err;
    logic [31:0] exp_dat;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  always @(negedge clk) begin
    if (!rst && (wb.wb_ack_o || wb.wb_err_o)) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response: ack=%0b err=%0b dat=%h, required no response",
                 wb.wb_ack_o, wb.wb_err_o, wb.wb_dat_o);
      end else begin
        e = sb.pop_front();
        if (wb.wb_ack_o !== ~e.err || wb.wb_err_o !== e.err || wb.wb_dat_o !== e.dat) begin
          errors++;
          $display("FAIL %s: ack=%0b err=%0b dat=%h, required ack=%0b err=%0b dat=%h",
                   e.name, wb.wb_ack_o, wb.wb_err_o, wb.wb_dat_o, ~e.err, e.err, e.dat);
        end
      end
    end
  end

  // called at a negedge; returns at the negedge showing the response, acc = accept edge index
  task automatic xfer(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input logic exp_err, input logic [31:0] exp_dat,
                      input string name, output int acc);
    exp_t e;
    bit   got;
    e.name = name; e.err = exp_err; e.dat = exp_dat;
    sb.push_back(e);
    wb.wb_adr_i = adr; wb.wb_dat_i = dat; wb.wb_sel_i = sel; wb.wb_we_i = we;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (wb.wb_ack_o || wb.wb_err_o) got = 1'b1;
    end
    acc = cyc_cnt;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no response within 8 cycles, required one", name);
      void'(sb.pop_back());
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (wb.wb_ack_o !== 1'b0 || wb.wb_err_o !== 1'b0 || wb.wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL %s: ack=%0b err=%0b dat=%h, required ack=0 err=0 dat=0",
               name, wb.wb_ack_o, wb.wb_err_o, wb.wb_dat_o);
    end
  endtask

  initial begin
    int          acc_w, acc_r;
    logic [31:0] exp_cyc;
    logic [5:0]  pattern;

    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
    wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;

    vecs.push_back('{16'h0000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0001_0000, "rd_version"});
    vecs.push_back('{16'h0004, 32'h0, 4'hF, 1'b0, 1'b0, 32'h3,         "rd_tileid"});
    vecs.push_back('{16'h001C, 32'h0, 4'hF, 1'b0, 1'b0, 32'h22,        "rd_flags"});
    vecs.push_back('{16'h0008, 32'h0, 4'hF, 1'b0, 1'b0, 32'h4,         "rd_numtiles"});
    vecs.push_back('{16'h000C, 32'h0, 4'hF, 1'b0, 1'b0, 32'h6,         "rd_corebase"});
    vecs.push_back('{16'h0010, 32'h0, 4'hF, 1'b0, 1'b0, 32'h8000,      "rd_lmem"});
    vecs.push_back('{16'h0014, 32'h0, 4'hF, 1'b0, 1'b0, 32'h10_0000,   "rd_gmem"});
    vecs.push_back('{16'h0020, 32'h0, 4'hF, 1'b0, 1'b0, 32'h4,         "rd_dma_entries"});
    vecs.push_back('{16'h0024, 32'h0, 4'hF, 1'b0, 1'b0, 32'h2,         "rd_numcts"});
    vecs.push_back('{16'h0028, 32'h0, 4'hF, 1'b0, 1'b0, 32'h2,         "rd_cores_per_tile"});
    vecs.push_back('{16'h002C, 32'h0, 4'hF, 1'b0, 1'b0, 32'h8,         "rd_total_cores"});
    vecs.push_back('{16'h0007, 32'h0, 4'hF, 1'b0, 1'b0, 32'h3,         "rd_tileid_lsb_ignored"});
    vecs.push_back('{16'h0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0,         "rd_ctlist0"});
    vecs.push_back('{16'h0204, 32'h0, 4'hF, 1'b0, 1'b0, 32'h5,         "rd_ctlist1"});
    vecs.push_back('{16'h0208, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0,         "rd_ctlist2_beyond"});
    vecs.push_back('{16'h02FC, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0,         "rd_ctlist63"});
    vecs.push_back('{16'h0034, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0, "wr_scratch"});
    vecs.push_back('{16'h0034, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, "rd_scratch"});
    vecs.push_back('{16'h0034, 32'h1234_5678, 4'h3, 1'b1, 1'b1, 32'h0, "wr_scratch_partial"});
    vecs.push_back('{16'h0034, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, "rd_scratch_kept"});
    vecs.push_back('{16'h0004, 32'h5555_5555, 4'hF, 1'b1, 1'b1, 32'h0, "wr_ro_tileid"});
    vecs.push_back('{16'h0004, 32'h0, 4'hF, 1'b0, 1'b0, 32'h3,         "rd_tileid_kept"});
    vecs.push_back('{16'h0100, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0,         "rd_unmapped_100"});
    vecs.push_back('{16'h0038, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0,         "rd_unmapped_38"});
    vecs.push_back('{16'h01FC, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0,         "rd_unmapped_1fc"});
    vecs.push_back('{16'h0300, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0,         "rd_unmapped_300"});
    vecs.push_back('{16'h0030, 32'h0, 4'h7, 1'b1, 1'b1, 32'h0,         "wr_cycles_partial"});

    repeat (2) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      xfer(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we,
           vecs[i].exp_err, vecs[i].exp_dat, vecs[i].name, acc_w);
      @(negedge clk);
    end

    // CYCLES wrap: expected value derived from the accept-edge distance
    for (int gap = 2; gap <= 3; gap++) begin
      xfer(NACONF_CYCLES, 32'hFFFF_FFFE, 4'hF, 1'b1, 1'b0, 32'h0, "wr_cycles", acc_w);
      repeat (gap) @(negedge clk);
      exp_cyc = 32'hFFFF_FFFE + 32'(cyc_cnt - acc_w);
      xfer(NACONF_CYCLES, 32'h0, 4'hF, 1'b0, 1'b0, exp_cyc, "rd_cycles_wrap", acc_r);
      @(negedge clk);
    end

    // strobe held six cycles: responses on cycles 1, 3, 5
    for (int k = 0; k < 3; k++) sb.push_back('{"held_stb_rd", 1'b0, 32'h0001_0000});
    wb.wb_adr_i = NACONF_VERSION; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pattern[k] = wb.wb_ack_o;
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    checks++;
    if (pattern !== 6'b010101) begin
      errors++;
      $display("FAIL held_stb_pattern: ack pattern=%b, required %b", pattern, 6'b010101);
    end
    @(negedge clk);

    // reset in the accept cycle discards the pending response
    wb.wb_adr_i = NACONF_SCRATCH; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_idle_outputs("reset_mid_txn");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_idle_outputs("reset_held");
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    rst = 1'b0;
    xfer(NACONF_CYCLES, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "rd_cycles_after_reset", acc_r);
    @(negedge clk);
    xfer(NACONF_SCRATCH, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "rd_scratch_after_reset", acc_r);
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/soc_networkadapter_configuration.md
# soc_networkadapter_configuration

Memory-mapped, read-mostly configuration register slave inside each compute tile's network adapter. It consumes the derived system configuration (`config_t`) plus tile identity, and exposes them to software over a classic Wishbone slave port. It also provides a free-running cycle counter and a scratch register. It sits directly downstream of the configuration package and is the only path by which tile software discovers system topology.

## Interface
Parameters:
- `CONFIG`, no default (must be set): derived `config_t` for the system.
- `TILEID`, 0: index of this tile.
- `COREBASE`, 0: global index of this tile's first core.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_adr_i`  in  16  byte address; bits [1:0] are ignored.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_dat_o`  out  32  read data, registered.
- `wb_ack_o`  out  1  normal termination, registered.
- `wb_err_o`  out  1  error termination, registered.

## Operation
Register map (byte offsets):
- RO words:
  - 0x00 VERSION = 0x0001_0000
  - 0x04 TILEID
  - 0x08 NUMTILES
  - 0x0C COREBASE
  - 0x10 LMEM_SIZE
  - 0x14 GMEM_SIZE
  - 0x18 GMEM_TILE
  - 0x20 NA_DMA_ENTRIES
  - 0x24 NUMCTS
  - 0x28 CORES_PER_TILE
  - 0x2C TOTAL_NUM_CORES
- 0x1C FLAGS (RO). Bit assignments:
  - bit0 NA_ENABLE_MPSIMPLE
  - bit1 NA_ENABLE_DMA
  - bit2 NA_DMA_GENIRQ
  - bit3 ENABLE_DM
  - bit4 ENABLE_PGAS
  - bit5 USE_DEBUG
  - bit6 NOC_ENABLE_VCHANNELS
  - bits [31:7] = 0
- 0x30 CYCLES (RW): 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
- 0x34 SCRATCH (RW).
- 0x200 + 4·i, i = 0..63, CTLIST[i] (RO):
  - returns {16'h0, CTLIST[i]} when i < NUMCTS;
  - returns 0 otherwise; the response is still ack.
- Any other offset (0x38–0x1FC, ≥0x300) is unmapped → err.
- Writes:
  - A write to a RO offset terminates with err and has no side effect.
  - A write to CYCLES or SCRATCH with `wb_sel_i` ≠ 4'hF terminates with err and has no side effect.
  - Partial writes are not supported.
- A CYCLES write loads `wb_dat_i` and overrides that cycle's increment. Counting resumes from the loaded value on the next cycle.
- A CYCLES read returns the counter value in the accept cycle.

## Timing
- Accept condition: `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
- Response:
  - Exactly one of `wb_ack_o` / `wb_err_o` is asserted in the cycle after accept, for exactly one cycle.
  - `wb_dat_o` is valid in that same cycle. It is 0 on err and on writes.
- Because the response register blocks accept, back-to-back strobes are serviced every second cycle. Latency is 1, throughput is 1 per 2 cycles.
- Register updates (SCRATCH/CYCLES) take effect on the accept edge. A read of the same register in the next transaction returns the new value.
- `wb_stb_i` dropped before the response: the response is still issued, and the master ignores it.
- Reset values:
  - `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0
  - CYCLES = 0, SCRATCH = 0
- Reset mid-transaction: the pending response is discarded immediately (asynchronous). The master must retry.
- No other state machine states exist beyond IDLE/RESPOND, which is implied by the response register.

## Structure
- Register offset localparams (`NACONF_*`) and a function packing the FLAGS word from `config_t` go in shared package `soc_optimsoc_config`, so that drivers' headers and the bench share them.
- Single module; no sub-module is warranted. The CTLIST read is a 64-entry combinational mux indexed by `wb_adr_i[7:2]`.

## Test plan
- After reset, read 0x00, 0x04, 0x1C with TILEID=3, NA_ENABLE_DMA=1, USE_DEBUG=1. Required:
  - 0x00 acks 0x0001_0000.
  - 0x04 acks 0x3.
  - 0x1C acks 0x22.
- NUMCTS=2, CTLIST[0]=0, CTLIST[1]=5. Read 0x200, 0x204, 0x208:
  - 0x200 → 0x0.
  - 0x204 → 0x5.
  - 0x208 → 0x0, all ack.
- Write 0xDEAD_BEEF to 0x34 with sel 4'hF, then read 0x34 → ack, 0xDEAD_BEEF. Write 0x34 with sel 4'h3 → err, and SCRATCH is unchanged.
- Write 0xFFFF_FFFE to 0x30, then read 0x30 on the next accept → wrap observed: returns 0x0000_0000 or 0x0000_0001 depending on the gap. Check exact value against the cycle count.
- Write to 0x04 → err, no change. Read 0x100 → err, dat 0. Hold stb high for 6 cycles → ack pulses at cycles 1, 3, 5 only.
- Assert `rst` in the accept cycle → no ack/err is produced, and all outputs read 0 during reset.
